// File: rtl/hrv_rmssd_stream_if.sv
// Bundle of the serial RR-interval input stream and the RMSSD result/status outputs.
// The master side drives the serial stream and clear; the slave side is the RMSSD engine.
interface hrv_rmssd_stream_if #(
    parameter int RR_W = 8
) ();
    logic            clr;
    logic            bit_in;
    logic            bit_valid;
    logic            rr_valid;
    logic [RR_W-1:0] rmssd_out;
    logic            done;
    logic            busy;
    logic            frame_err;
    logic            overrun;

    modport master (
        output clr, bit_in, bit_valid, rr_valid,
        input  rmssd_out, done, busy, frame_err, overrun
    );

    modport slave (
        input  clr, bit_in, bit_valid, rr_valid,
        output rmssd_out, done, busy, frame_err, overrun
    );
endinterface

// File: rtl/hrv_rmssd_stream.sv
// Streaming RMSSD engine: deserialises RR intervals into a circular buffer, accumulates squared
// successive differences, takes the mean and a bit-serial restoring integer square root.
module hrv_rmssd_stream #(
    parameter int RR_W = 8,
    parameter int WIN  = 8,
    parameter int MODE = 0
) (
    input  logic clk,
    input  logic rst,
    hrv_rmssd_stream_if.slave bus
);
    localparam int LOG2W  = $clog2(WIN);
    localparam int DEPTH  = WIN + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int BC_W   = $clog2(RR_W);
    localparam int SUM_W  = 2 * RR_W + LOG2W;
    localparam int REM_W  = RR_W + 2;
    localparam int STEP_W = $clog2((WIN > RR_W) ? WIN : RR_W) + 1;

    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(RR_W - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [STEP_W-1:0] ACC_LAST  = STEP_W'(WIN - 1);
    localparam logic [STEP_W-1:0] ROOT_LAST = STEP_W'(RR_W - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ACCUM   = 2'd1,
        ROOT    = 2'd2,
        OUT     = 2'd3
    } state_t;

    function automatic logic [RR_W-1:0] abs_diff(input logic [RR_W-1:0] a, input logic [RR_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
    endfunction

    state_t              state_r;
    logic [BC_W-1:0]     bit_cnt_r;
    logic [RR_W-2:0]     word_r;
    logic [RR_W-1:0]     buf_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [FILL_W-1:0]   fill_r;
    logic [STEP_W-1:0]   step_r;
    logic [SUM_W-1:0]    sum_r;
    logic [2*RR_W-1:0]   rad_r;
    logic [REM_W-1:0]    rem_r;
    logic [RR_W-1:0]     root_r;
    logic [RR_W-1:0]     rmssd_r;
    logic                done_r;
    logic                busy_r;
    logic                frame_err_r;
    logic                overrun_r;

    logic [RR_W-1:0]     word_s;
    logic                at_last_s;
    logic                complete_s;
    logic                frame_bad_s;
    logic                busy_s;
    logic                wr_s;
    logic                overrun_s;
    logic [FILL_W-1:0]   fill_inc_s;
    logic                start_s;
    logic [PTR_W-1:0]    rd_nxt_s;
    logic [RR_W-1:0]     d_s;
    logic [2*RR_W-1:0]   sq_s;
    logic [SUM_W-1:0]    sum_next_s;
    logic [2*RR_W-1:0]   mean_s;
    logic [REM_W+1:0]    rem_t_s;
    logic [REM_W+1:0]    trial_s;
    logic [REM_W+1:0]    rem_sub_s;
    logic                ge_s;

    // A word completes on its RR_W-th bit only when the end marker lands exactly there.
    assign word_s      = {word_r, bus.bit_in};
    assign at_last_s   = (bit_cnt_r == BC_LAST);
    assign complete_s  = bus.bit_valid & bus.rr_valid & at_last_s;
    assign frame_bad_s = bus.bit_valid & (bus.rr_valid ^ at_last_s);
    assign busy_s      = (state_r == ACCUM) | (state_r == ROOT);
    assign wr_s        = complete_s & ~busy_s & ~bus.clr;
    assign overrun_s   = complete_s & busy_s & ~bus.clr;
    assign fill_inc_s  = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_W'(1));
    assign start_s     = wr_s & (fill_inc_s == FILL_FULL) & ((state_r == COLLECT) | (state_r == OUT));

    assign rd_nxt_s    = ptr_inc(rd_ptr_r);
    assign d_s         = abs_diff(buf_r[rd_nxt_s], buf_r[rd_ptr_r]);
    assign sq_s        = {{RR_W{1'b0}}, d_s} * {{RR_W{1'b0}}, d_s};
    assign sum_next_s  = sum_r + {{LOG2W{1'b0}}, sq_s};
    assign mean_s      = (2*RR_W)'(sum_next_s >> LOG2W);

    // One restoring square-root digit: bring down two radicand bits, try subtracting 4*root+1.
    assign rem_t_s     = {rem_r, rad_r[2*RR_W-1 -: 2]};
    assign trial_s     = {2'b00, root_r, 2'b01};
    assign ge_s        = (rem_t_s >= trial_s);
    assign rem_sub_s   = rem_t_s - trial_s;

    assign bus.rmssd_out = rmssd_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;

    // Serial deserialiser: shifts MSB first and restarts after every completed or discarded word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= {BC_W{1'b0}};
            word_r    <= {(RR_W-1){1'b0}};
        end else if (bus.clr) begin
            bit_cnt_r <= {BC_W{1'b0}};
            word_r    <= {(RR_W-1){1'b0}};
        end else if (bus.bit_valid) begin
            word_r    <= word_s[RR_W-2:0];
            bit_cnt_r <= (bus.rr_valid | at_last_s) ? {BC_W{1'b0}} : (bit_cnt_r + BC_W'(1));
        end
    end

    // Sample storage; contents are don't-care until refilled, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            buf_r[wr_ptr_r] <= word_s;
        end
    end

    // Control FSM with its datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= COLLECT;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            step_r      <= {STEP_W{1'b0}};
            sum_r       <= {SUM_W{1'b0}};
            rad_r       <= {(2*RR_W){1'b0}};
            rem_r       <= {REM_W{1'b0}};
            root_r      <= {RR_W{1'b0}};
            rmssd_r     <= {RR_W{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            frame_err_r <= frame_bad_s & ~bus.clr;
            overrun_r   <= overrun_s;
            if (bus.clr) begin
                state_r <= COLLECT;
                fill_r  <= {FILL_W{1'b0}};
                step_r  <= {STEP_W{1'b0}};
                busy_r  <= 1'b0;
            end else begin
                if (wr_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                    fill_r   <= fill_inc_s;
                end
                if (state_r == OUT) begin
                    rmssd_r <= root_r;
                    done_r  <= 1'b1;
                end
                // The slot after the one just written holds the oldest sample of the window.
                if (start_s) begin
                    state_r  <= ACCUM;
                    busy_r   <= 1'b1;
                    sum_r    <= {SUM_W{1'b0}};
                    step_r   <= {STEP_W{1'b0}};
                    rd_ptr_r <= ptr_inc(wr_ptr_r);
                end else begin
                    case (state_r)
                        COLLECT: begin
                            state_r <= COLLECT;
                        end
                        ACCUM: begin
                            sum_r    <= sum_next_s;
                            rd_ptr_r <= rd_nxt_s;
                            step_r   <= step_r + STEP_W'(1);
                            if (step_r == ACC_LAST) begin
                                state_r <= ROOT;
                                step_r  <= {STEP_W{1'b0}};
                                rad_r   <= mean_s;
                                rem_r   <= {REM_W{1'b0}};
                                root_r  <= {RR_W{1'b0}};
                            end
                        end
                        ROOT: begin
                            rem_r  <= ge_s ? REM_W'(rem_sub_s) : REM_W'(rem_t_s);
                            root_r <= {root_r[RR_W-2:0], ge_s};
                            rad_r  <= {rad_r[2*RR_W-3:0], 2'b00};
                            step_r <= step_r + STEP_W'(1);
                            if (step_r == ROOT_LAST) begin
                                state_r <= OUT;
                                busy_r  <= 1'b0;
                                step_r  <= {STEP_W{1'b0}};
                                if (MODE == 0) begin
                                    fill_r <= {FILL_W{1'b0}};
                                end
                            end
                        end
                        OUT: begin
                            state_r <= COLLECT;
                        end
                        default: begin
                            state_r <= COLLECT;
                            busy_r  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_hrv_rmssd_stream.sv
// Directed bench for hrv_rmssd_stream: block-mode vector table plus hand-written corner sequences,
// with a second instance in sliding mode selected by sel.
module tb_hrv_rmssd_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic clr = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic rr_valid = 1'b0;

    logic [7:0] o_rmssd;
    logic       o_done, o_busy, o_ferr, o_ovr;

    int cyc = 0;
    int word_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    hrv_rmssd_stream_if #(.RR_W(8)) if0 ();
    hrv_rmssd_stream_if #(.RR_W(8)) if1 ();

    hrv_rmssd_stream #(.RR_W(8), .WIN(8), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    hrv_rmssd_stream #(.RR_W(8), .WIN(8), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign if0.clr       = clr & ~sel;
    assign if0.bit_in    = bit_in;
    assign if0.bit_valid = bit_valid & ~sel;
    assign if0.rr_valid  = rr_valid & ~sel;
    assign if1.clr       = clr & sel;
    assign if1.bit_in    = bit_in;
    assign if1.bit_valid = bit_valid & sel;
    assign if1.rr_valid  = rr_valid & sel;

    assign o_rmssd = sel ? if1.rmssd_out : if0.rmssd_out;
    assign o_done  = sel ? if1.done      : if0.done;
    assign o_busy  = sel ? if1.busy      : if0.busy;
    assign o_ferr  = sel ? if1.frame_err : if0.frame_err;
    assign o_ovr   = sel ? if1.overrun   : if0.overrun;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (o_ferr) ferr_cnt = ferr_cnt + 1;
        if (o_ovr)  ovr_cnt  = ovr_cnt + 1;
    end

    typedef struct {
        logic [8:0][7:0] w;
        int              exp;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string nm, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input bit mark);
        for (int i = 0; i < n; i++) begin
            bit_in    = v[n-1-i];
            bit_valid = 1'b1;
            rr_valid  = mark && (i == n - 1);
            if (i == n - 1) word_cyc = cyc;
            tick();
        end
        bit_valid = 1'b0;
        rr_valid  = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        send_bits({8'h00, w}, 8, 1'b1);
    endtask

    task automatic send_alt(input logic [7:0] a, input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) send_word((k % 2 == 0) ? a : b);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < budget) begin
            tick();
            k++;
        end
        check(nm, (done_cnt > start) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int d0;
        int f0;
        int v0;
        int last;

        for (int k = 0; k < 9; k++) begin
            vt[0].w[k] = (k % 2 == 0) ? 8'd100 : 8'd110;
            vt[1].w[k] = (k % 2 == 0) ? 8'd0 : 8'd255;
            vt[2].w[k] = 8'd50;
            vt[3].w[k] = 8'(k * (k + 1) / 2);
            vt[4].w[k] = (k % 2 == 0) ? 8'd20 : 8'd31;
        end
        vt[0].exp = 10;
        vt[1].exp = 255;
        vt[2].exp = 0;
        vt[3].exp = 5;
        vt[4].exp = 11;

        // reset state
        idle(2);
        check("rst_rmssd", int'(o_rmssd), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ferr", int'(o_ferr), 0);
        check("rst_ovr", int'(o_ovr), 0);
        rst = 1'b0;
        tick();

        // block-mode table
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            for (int k = 0; k < 9; k++) send_word(vt[i].w[k]);
            last = word_cyc;
            wait_done($sformatf("vec%0d_done", i), 40);
            check($sformatf("vec%0d_rmssd", i), int'(o_rmssd), vt[i].exp);
            check($sformatf("vec%0d_latency", i), done_cyc - last, 18);
            idle(3);
            check($sformatf("vec%0d_pulses", i), done_cnt - d0, 1);
        end

        // framing errors leave the buffer fill untouched
        f0 = ferr_cnt;
        d0 = done_cnt;
        send_bits(16'h0015, 5, 1'b1);
        tick();
        check("ferr_early_marker", ferr_cnt - f0, 1);
        send_bits(16'h00A5, 8, 1'b0);
        tick();
        check("ferr_missing_marker", ferr_cnt - f0, 2);
        send_alt(8'd100, 8'd110, 8);
        idle(30);
        check("ferr_no_early_done", done_cnt - d0, 0);
        send_word(8'd100);
        last = word_cyc;
        wait_done("ferr_done", 40);
        check("ferr_rmssd", int'(o_rmssd), 10);
        check("ferr_latency", done_cyc - last, 18);
        check("ferr_count_stable", ferr_cnt - f0, 2);

        // word completed while busy is dropped with overrun
        v0 = ovr_cnt;
        send_alt(8'd50, 8'd50, 9);
        last = word_cyc;
        check("ovr_busy_high", int'(o_busy), 1);
        send_word(8'd255);
        tick();
        check("ovr_pulse", ovr_cnt - v0, 1);
        wait_done("ovr_done", 40);
        check("ovr_rmssd", int'(o_rmssd), 0);
        check("ovr_latency", done_cyc - last, 18);

        // clr mid-accumulation aborts without done and keeps the old result
        d0 = done_cnt;
        send_alt(8'd0, 8'd255, 9);
        idle(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", int'(o_busy), 0);
        idle(30);
        check("clr_no_done", done_cnt - d0, 0);
        check("clr_rmssd_kept", int'(o_rmssd), 0);
        send_alt(8'd100, 8'd110, 9);
        wait_done("clr_after_done", 40);
        check("clr_after_rmssd", int'(o_rmssd), 10);

        // reset during ROOT aborts; nine fresh words are needed afterwards
        d0 = done_cnt;
        send_alt(8'd0, 8'd255, 9);
        idle(12);
        rst = 1'b1;
        #1;
        check("rroot_rmssd", int'(o_rmssd), 0);
        check("rroot_busy", int'(o_busy), 0);
        check("rroot_done", int'(o_done), 0);
        tick();
        rst = 1'b0;
        idle(30);
        check("rroot_no_done", done_cnt - d0, 0);
        send_alt(8'd100, 8'd110, 8);
        idle(25);
        check("rroot_need_nine", done_cnt - d0, 0);
        send_word(8'd100);
        wait_done("rroot_done_after", 40);
        check("rroot_rmssd_after", int'(o_rmssd), 10);

        // sliding mode
        sel = 1'b1;
        do_reset();
        d0 = done_cnt;
        send_alt(8'd100, 8'd110, 9);
        wait_done("slide_first_done", 40);
        check("slide_first_rmssd", int'(o_rmssd), 10);
        idle(2);
        send_word(8'd120);
        last = word_cyc;
        wait_done("slide_second_done", 40);
        check("slide_second_rmssd", int'(o_rmssd), 11);
        check("slide_latency", done_cyc - last, 18);
        idle(3);
        check("slide_pulses", done_cnt - d0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hrv_rmssd_stream.md
HRV_RMSSD_STREAM -- requirements
Module: hrv_rmssd_stream

Interface
REQ-001 Parameter RR_W, default 8: RR-interval sample width in bits, legal range 4..16.
REQ-002 Parameter WIN, default 8: number of successive differences per result, power of two, legal range 2..32; the buffer holds WIN+1 samples.
REQ-003 Parameter MODE, default 0: 0 = block mode (non-overlapping windows), 1 = sliding mode (result after every new sample once the buffer is full).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 clr  input  1  synchronous clear of buffer fill, bit counter and flags; rmssd_out is retained.
REQ-007 bit_in  input  1  serial sample data, MSB first.
REQ-008 bit_valid  input  1  bit_in is sampled on this cycle.
REQ-009 rr_valid  input  1  end-of-word marker, qualified only when bit_valid is high.
REQ-010 rmssd_out  output  RR_W  last computed RMSSD, registered.
REQ-011 done  output  1  one-cycle pulse when rmssd_out updates.
REQ-012 busy  output  1  high while in the ACCUM or ROOT state.
REQ-013 frame_err  output  1  one-cycle pulse on a malformed word.
REQ-014 overrun  output  1  one-cycle pulse when a complete word is dropped because busy is high.

Function
REQ-015 On each bit_valid cycle, bit_in shall shift into the word register and the bit counter shall increment.
REQ-016 A word completes when bit_valid=1, rr_valid=1 and bit_counter==RR_W-1; the completed word includes the current bit.
REQ-017 If bit_valid=1 and rr_valid=1 with bit_counter!=RR_W-1, the design shall pulse frame_err, discard the partial word and clear the counter.
REQ-018 If RR_W bits arrive without rr_valid, the design shall pulse frame_err on the RR_W-th bit and clear the counter.
REQ-019 The bit counter shall be cleared after every completed or discarded word.
REQ-020 Serial reception shall continue while busy is high.
REQ-021 A word completing while busy is high shall not be written to the buffer, and overrun shall pulse.
REQ-022 Completed words shall be written into a circular buffer of depth WIN+1, and the fill count shall saturate at WIN+1.
REQ-023 States are COLLECT, ACCUM, ROOT and OUT; COLLECT is the reset state.
REQ-024 COLLECT->ACCUM on the cycle after a write that makes fill==WIN+1; in MODE=1, also after every later write.
REQ-025 In ACCUM, one difference per cycle shall be processed, oldest pair first, for exactly WIN cycles.
REQ-026 Each ACCUM step shall add d*d to the sum, where d=|rr[k]-rr[k-1]| (RR_W bits, unsigned).
REQ-027 The sum shall be 2*RR_W+log2(WIN) bits wide, cleared on ACCUM entry, and shall never overflow.
REQ-028 On ACCUM->ROOT, the mean shall be sum>>log2(WIN), truncated.
REQ-029 ROOT shall compute the restoring integer square root floor(sqrt(mean)), one result bit per cycle, for RR_W cycles.
REQ-030 The root result always fits in RR_W bits; no saturation logic is required.
REQ-031 In OUT (one cycle), rmssd_out shall load the root result, done shall pulse, and the state shall return to COLLECT.
REQ-032 In MODE=0, fill shall reset to 0 on entry to OUT; MODE=1 keeps fill==WIN+1.
REQ-033 Latency from the final word's completing cycle to done shall be WIN+RR_W+2 cycles.
REQ-034 clr shall return the state to COLLECT, zero fill and the bit counter, and suppress done that cycle; clr has priority over all other events.
REQ-035 A completing word and clr in the same cycle: the word is discarded.

Reset
REQ-036 While rst is high: rmssd_out=0, done=0, busy=0, frame_err=0, overrun=0, state=COLLECT, fill=0, bit counter=0, sum=0.
REQ-037 Buffer contents need not be reset.
REQ-038 Reset asserted mid-ACCUM or mid-ROOT shall abort the computation with no done pulse; the first result after release requires WIN+1 fresh words.

Verification
REQ-039 Defaults, MODE=0: 9 words alternating 100,110 -> one done pulse, rmssd_out=10, done exactly 18 cycles after the last word.
REQ-040 Defaults, MODE=0: 9 words alternating 0,255 -> rmssd_out=255 (no overflow); 9 constant words 50 -> rmssd_out=0.
REQ-041 Defaults, MODE=1: the 9 words of REQ-039 (ending with 100), then 120 -> second done with rmssd_out=11 (sum 1100, mean 137).
REQ-042 rr_valid with bit_valid after the 5th bit -> frame_err pulse, fill unchanged, next 8-bit word accepted normally.
REQ-043 A word completed during ACCUM -> overrun pulse, no buffer write, result unchanged.
REQ-044 rst asserted in ROOT -> all outputs 0 immediately, no done; 9 new words then produce a correct result.
